// File: rtl/addsub_accum_seq_if.sv
// Operand-beat input stream and result output stream of the add/sub accumulator.
// The master side is the packet producer; the slave side is the accumulator.
interface addsub_accum_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_carry;
  logic             out_zero;
  logic [7:0]       out_count;

  modport master (
    output in_valid, in_data, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_carry, out_zero, out_count
  );

  modport slave (
    input  in_valid, in_data, in_op, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_carry, out_zero, out_count
  );
endinterface

// File: rtl/addsub_accum_seq.sv
// Packet accumulator: applies LOAD/ADD/SUB/CLEAR per accepted beat and presents
// one registered result with sticky overflow/carry flags when the packet closes.
module addsub_accum_seq #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input logic clk,
    input logic rst_n,
    addsub_accum_seq_if.slave bus
);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_e;

    state_e           state, state_next;
    logic [WIDTH-1:0] acc;
    logic             ovf, carry;
    logic [7:0]       count;

    logic             xfer, first;
    op_e              op;
    logic [WIDTH-1:0] base, operand_b, sum, sat_val, acc_next;
    logic             cout, sum_ovf, is_sub, is_arith;
    logic             ovf_next, carry_next;
    logic [7:0]       count_base, count_next;

    assign bus.in_ready  = (state != S_HOLD);
    assign bus.out_valid = (state == S_HOLD);

    assign xfer  = bus.in_valid && bus.in_ready;
    assign first = (state == S_IDLE);
    assign op    = op_e'(bus.in_op);

    // A new packet starts from a clean slate: base 0, flags and count cleared.
    assign base       = first ? '0 : acc;
    assign count_base = first ? 8'd0 : count;

    // Shared two's-complement adder: SUB is A + ~B with carry-in 1.
    assign is_sub    = (op == OP_SUB);
    assign is_arith  = (op == OP_ADD) || is_sub;
    assign operand_b = is_sub ? ~bus.in_data : bus.in_data;
    assign {cout, sum} = {1'b0, base} + {1'b0, operand_b} + {{WIDTH{1'b0}}, is_sub};

    // Using the inverted operand makes one rule cover both ADD and SUB overflow.
    assign sum_ovf = (base[WIDTH-1] == operand_b[WIDTH-1]) && (sum[WIDTH-1] != base[WIDTH-1]);
    assign sat_val = base[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        acc_next = base;
        unique case (op)
            OP_LOAD:  acc_next = bus.in_data;
            OP_ADD,
            OP_SUB:   acc_next = (SAT && sum_ovf) ? sat_val : sum;
            OP_CLEAR: acc_next = '0;
            default:  acc_next = base;
        endcase
    end

    // Borrow on SUB is the inverse of the adder carry-out.
    assign ovf_next   = (first ? 1'b0 : ovf) | (is_arith && sum_ovf);
    assign carry_next = (first ? 1'b0 : carry) |
                        ((op == OP_ADD) && cout) | (is_sub && !cout);
    assign count_next = (count_base == 8'hFF) ? 8'hFF : count_base + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE,
            S_ACCUM: if (xfer) state_next = bus.in_last ? S_HOLD : S_ACCUM;
            S_HOLD:  if (bus.out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            ovf           <= 1'b0;
            carry         <= 1'b0;
            count         <= 8'd0;
            bus.out_data  <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_carry <= 1'b0;
            bus.out_zero  <= 1'b0;
            bus.out_count <= 8'd0;
        end else if (xfer) begin
            acc   <= acc_next;
            ovf   <= ovf_next;
            carry <= carry_next;
            count <= count_next;
            // Result fields are captured only at packet close so they hold after the handshake.
            if (bus.in_last) begin
                bus.out_data  <= acc_next;
                bus.out_ovf   <= ovf_next;
                bus.out_carry <= carry_next;
                bus.out_zero  <= (acc_next == '0);
                bus.out_count <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_addsub_accum_seq.sv
// Bench for addsub_accum_seq: wrap (SAT=0) and saturating (SAT=1) instances
// share stimulus; results are compared with tables and an arithmetic model.
module tb_addsub_accum_seq;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int MAXS = (1 << (W - 1)) - 1;
  localparam int MINS = -(1 << (W - 1));
  localparam int LD = 0, AD = 1, SB = 2, CL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_accum_seq_if #(.WIDTH(W)) bus0 ();
  addsub_accum_seq_if #(.WIDTH(W)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_data   = bus0.in_data;
  assign bus1.in_op     = bus0.in_op;
  assign bus1.in_last   = bus0.in_last;
  assign bus1.out_ready = bus0.out_ready;

  addsub_accum_seq #(.WIDTH(W), .SAT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  addsub_accum_seq #(.WIDTH(W), .SAT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain signed/unsigned integer arithmetic, index 0 = wrap, 1 = saturate.
  int m_acc[2];
  bit m_ovf[2];
  bit m_carry[2];
  int m_cnt;
  bit m_open;

  function automatic int sx(input int v);
    return (v > MAXS) ? v - (1 << W) : v;
  endfunction

  task automatic model_beat(input int op, input int d);
    if (!m_open) begin
      m_cnt = 0;
      for (int s = 0; s < 2; s++) begin
        m_ovf[s]   = 1'b0;
        m_carry[s] = 1'b0;
      end
    end
    for (int s = 0; s < 2; s++) begin
      int a;
      int t;
      bit o;
      a = m_open ? m_acc[s] : 0;
      t = 0;
      o = 1'b0;
      case (op)
        LD: m_acc[s] = d;
        CL: m_acc[s] = 0;
        default: begin
          if (op == AD) begin
            t = sx(a) + sx(d);
            if (a + d > MASK) m_carry[s] = 1'b1;
          end else begin
            t = sx(a) - sx(d);
            if (a < d) m_carry[s] = 1'b1;
          end
          o = (t > MAXS) || (t < MINS);
          if (o) m_ovf[s] = 1'b1;
          if (o && s == 1) m_acc[s] = (t > 0 ? MAXS : MINS) & MASK;
          else             m_acc[s] = t & MASK;
        end
      endcase
    end
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endtask

  // Present one beat and wait for it to transfer (inputs change #1 after an edge).
  task automatic drive(input int op, input int d, input bit last);
    int n;
    bus0.in_valid = 1'b1;
    bus0.in_op    = 2'(op);
    bus0.in_data  = W'(d);
    bus0.in_last  = last;
    n = 0;
    while (!bus0.in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus0.in_ready) begin
      check("in_ready_timeout", 32'(bus0.in_ready), 32'd1);
    end else begin
      @(posedge clk);
      model_beat(op, d);
      m_open = !last;
      #1;
    end
    bus0.in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid0"}, 32'(bus0.out_valid), 32'd1);
    check({tag, "_valid1"}, 32'(bus1.out_valid), 32'd1);
    check({tag, "_data0"},  32'(bus0.out_data),  32'(m_acc[0]));
    check({tag, "_data1"},  32'(bus1.out_data),  32'(m_acc[1]));
    check({tag, "_ovf0"},   32'(bus0.out_ovf),   32'(m_ovf[0]));
    check({tag, "_ovf1"},   32'(bus1.out_ovf),   32'(m_ovf[1]));
    check({tag, "_carry0"}, 32'(bus0.out_carry), 32'(m_carry[0]));
    check({tag, "_carry1"}, 32'(bus1.out_carry), 32'(m_carry[1]));
    check({tag, "_zero0"},  32'(bus0.out_zero),  32'(m_acc[0] == 0));
    check({tag, "_zero1"},  32'(bus1.out_zero),  32'(m_acc[1] == 0));
    check({tag, "_count0"}, 32'(bus0.out_count), 32'(m_cnt));
    check({tag, "_count1"}, 32'(bus1.out_count), 32'(m_cnt));
  endtask

  task automatic ack(input int delay);
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.out_ready = 1'b0;
    check("ack_valid0_low", 32'(bus0.out_valid), 32'd0);
    check("ack_valid1_low", 32'(bus1.out_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus0.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus0.out_valid | bus1.out_valid), 32'd0);
    check({tag, "_out_data"},  32'(bus0.out_data | bus1.out_data),   32'd0);
    check({tag, "_out_flags"}, {29'd0, bus0.out_ovf | bus1.out_ovf,
                                bus0.out_carry | bus1.out_carry,
                                bus0.out_zero | bus1.out_zero}, 32'd0);
    check({tag, "_out_count"}, 32'(bus0.out_count | bus1.out_count), 32'd0);
  endtask

  typedef struct {
    int n;
    int op[4];
    int d[4];
    int data;
    int data_sat;
    int ovf;
    int carry;
    int zero;
    int count;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bus0.in_valid  = 1'b0;
    bus0.in_op     = 2'd0;
    bus0.in_data   = '0;
    bus0.in_last   = 1'b0;
    bus0.out_ready = 1'b0;
    m_open = 1'b0;
    m_cnt  = 0;
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = 0;
      m_ovf[s] = 1'b0;
      m_carry[s] = 1'b0;
    end

    tbl[0] = '{3, '{LD, AD, SB, 0}, '{'h10, 'h05, 'h03, 0}, 'h12, 'h12, 0, 0, 0, 3};
    tbl[1] = '{2, '{AD, AD, 0, 0},  '{'h70, 'h20, 0, 0},    'h90, 'h7F, 1, 0, 0, 2};
    tbl[2] = '{1, '{SB, 0, 0, 0},   '{'h01, 0, 0, 0},       'hFF, 'hFF, 0, 1, 0, 1};
    tbl[3] = '{1, '{LD, 0, 0, 0},   '{'h00, 0, 0, 0},       'h00, 'h00, 0, 0, 1, 1};
    tbl[4] = '{2, '{AD, SB, 0, 0},  '{'h80, 'h01, 0, 0},    'h7F, 'h80, 1, 0, 0, 2};
    tbl[5] = '{3, '{AD, AD, CL, 0}, '{'hFF, 'h01, 0, 0},    'h00, 'h00, 0, 1, 1, 3};

    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      for (int j = 0; j < tbl[i].n; j++) drive(tbl[i].op[j], tbl[i].d[j], j == tbl[i].n - 1);
      check({tag, "_valid"}, 32'(bus0.out_valid & bus1.out_valid), 32'd1);
      check({tag, "_data"},     32'(bus0.out_data),  32'(tbl[i].data));
      check({tag, "_data_sat"}, 32'(bus1.out_data),  32'(tbl[i].data_sat));
      check({tag, "_ovf"},      {30'd0, bus1.out_ovf, bus0.out_ovf},     32'(tbl[i].ovf * 3));
      check({tag, "_carry"},    {30'd0, bus1.out_carry, bus0.out_carry}, 32'(tbl[i].carry * 3));
      check({tag, "_zero"},     32'(bus0.out_zero),  32'(tbl[i].zero));
      check({tag, "_count"},    32'(bus0.out_count), 32'(tbl[i].count));
      ack(0);
    end

    // Backpressure: result held while a next beat waits with in_valid high.
    drive(LD, 'h55, 1'b1);
    check_result("bp_first");
    bus0.in_valid = 1'b1;
    bus0.in_op    = 2'(LD);
    bus0.in_data  = 8'h66;
    bus0.in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready_low", 32'(bus0.in_ready), 32'd0);
      check("bp_valid_held",   32'(bus0.out_valid), 32'd1);
      check("bp_data_held",    32'(bus0.out_data), 32'h55);
    end
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.out_ready = 1'b0;
    check("bp_valid_drop", 32'(bus0.out_valid), 32'd0);
    check("bp_ready_back", 32'(bus0.in_ready), 32'd1);
    @(posedge clk);
    model_beat(LD, 'h66);
    m_open = 1'b0;
    #1;
    bus0.in_valid = 1'b0;
    check_result("bp_next");
    ack(0);

    // Bubbles inside a packet.
    for (int j = 0; j < 4; j++) begin
      drive(AD, 1, j == 3);
      if (j < 3) begin
        @(posedge clk);
        #1;
      end
    end
    check("bubble_data",  32'(bus0.out_data), 32'h04);
    check("bubble_count", 32'(bus0.out_count), 32'd4);
    check_result("bubble");
    ack(1);

    // Count saturates at 255.
    for (int j = 0; j < 260; j++) drive(AD, 0, j == 259);
    check("count_sat", 32'(bus0.out_count), 32'd255);
    check_result("count_sat");
    ack(0);

    // Randomized packets with bubbles and output backpressure.
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
        drive($urandom_range(0, 3), $urandom_range(0, MASK), j == len - 1);
      end
      check_result($sformatf("rand%0d", p));
      ack($urandom_range(0, 3));
    end

    // Asynchronous reset while the result is held.
    drive(LD, 'h5A, 1'b1);
    check_result("pre_rst_hold");
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_hold");
    m_open = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-packet discards the open packet.
    drive(LD, 'h22, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    m_open = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(LD, 'h33, 1'b1);
    check("post_rst_data",  32'(bus0.out_data), 32'h33);
    check("post_rst_count", 32'(bus0.out_count), 32'd1);
    check_result("post_rst");
    ack(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
